// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared pipeline types: hazard sequencer state and the bundled stage control word.
package rv32i_types;

  typedef enum logic {
    RUN  = 1'b0,
    WAIT = 1'b1
  } hazard_state_t;

  typedef struct packed {
    logic load_pc;
    logic load_if_id;
    logic load_id_ex;
    logic load_ex_mem;
    logic load_mem_wb;
    logic flush_if_id;
    logic bubble_id_ex;
  } stage_ctrl_t;

  localparam stage_ctrl_t CTRL_HOLD   = stage_ctrl_t'(7'b00000_0_0);
  localparam stage_ctrl_t CTRL_RUN    = stage_ctrl_t'(7'b11111_0_0);
  localparam stage_ctrl_t CTRL_FLUSH  = stage_ctrl_t'(7'b11111_1_1);
  localparam stage_ctrl_t CTRL_BUBBLE = stage_ctrl_t'(7'b00111_0_1);

endpackage

// File: rtl/pipeline_hazard_ctrl_load_use_detect.sv
// Combinational load-use compare between the EX load destination and the ID sources.
module load_use_detect #(
  parameter int REG_ADDR_W = 5
) (
  input  logic                  ex_is_load_i,
  input  logic [REG_ADDR_W-1:0] ex_rd_i,
  input  logic [REG_ADDR_W-1:0] id_rs1_i,
  input  logic [REG_ADDR_W-1:0] id_rs2_i,
  input  logic                  id_uses_rs1_i,
  input  logic                  id_uses_rs2_i,
  output logic                  load_use_o
);

  logic rs1_hit;
  logic rs2_hit;

  // x0 is hardwired to zero, so a load targeting it never creates a dependency
  assign rs1_hit    = id_uses_rs1_i & (id_rs1_i == ex_rd_i);
  assign rs2_hit    = id_uses_rs2_i & (id_rs2_i == ex_rd_i);
  assign load_use_o = ex_is_load_i & (ex_rd_i != '0) & (rs1_hit | rs2_hit);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage RV32I pipeline.
// Optional performance counters are built when HAZARD_PERF_CNT_EN is defined.
module pipeline_hazard_ctrl
  import rv32i_types::*;
#(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  imem_read,
  input  logic                  imem_resp,
  input  logic                  dmem_read,
  input  logic                  dmem_write,
  input  logic                  dmem_resp,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_uses_rs1,
  input  logic                  id_uses_rs2,
  input  logic                  ex_is_load,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_redirect,
`ifdef HAZARD_PERF_CNT_EN
  output logic [CNT_W-1:0]      stall_cycles_o,
  output logic [CNT_W-1:0]      bubble_cnt_o,
  output logic [CNT_W-1:0]      flush_cnt_o,
`endif
  output logic                  load_pc,
  output logic                  load_if_id,
  output logic                  load_id_ex,
  output logic                  load_ex_mem,
  output logic                  load_mem_wb,
  output logic                  flush_if_id,
  output logic                  bubble_id_ex,
  output logic                  stall_o
);

  hazard_state_t state_q, state_d;
  logic          imem_done_q, imem_done_d;
  logic          dmem_done_q, dmem_done_d;
  logic          imem_done, dmem_done;
  logic          dmem_req;
  logic          imem_pend, dmem_pend, mem_stall;
  logic          load_use;
  stage_ctrl_t   ctrl;

  load_use_detect #(.REG_ADDR_W(REG_ADDR_W)) u_load_use_detect (
    .ex_is_load_i  (ex_is_load),
    .ex_rd_i       (ex_rd),
    .id_rs1_i      (id_rs1),
    .id_rs2_i      (id_rs2),
    .id_uses_rs1_i (id_uses_rs1),
    .id_uses_rs2_i (id_uses_rs2),
    .load_use_o    (load_use)
  );

  // Flags can only be live while waiting; qualifying with the state keeps RUN clean.
  assign imem_done = imem_done_q & (state_q == WAIT);
  assign dmem_done = dmem_done_q & (state_q == WAIT);
  assign dmem_req  = dmem_read | dmem_write;
  assign imem_pend = imem_read & ~imem_done & ~imem_resp;
  assign dmem_pend = dmem_req & ~dmem_done & ~dmem_resp;
  assign mem_stall = imem_pend | dmem_pend;

  always_comb begin
    state_d     = RUN;
    imem_done_d = 1'b0;
    dmem_done_d = 1'b0;
    // A response seen while the other port still stalls is held until the joint advance.
    if (mem_stall) begin
      state_d     = WAIT;
      imem_done_d = imem_done | (imem_read & imem_resp);
      dmem_done_d = dmem_done | (dmem_req & dmem_resp);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RUN;
      imem_done_q <= 1'b0;
      dmem_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      imem_done_q <= imem_done_d;
      dmem_done_q <= dmem_done_d;
    end
  end

  always_comb begin
    ctrl = CTRL_RUN;
    if (rst || mem_stall) ctrl = CTRL_HOLD;
    else if (ex_redirect) ctrl = CTRL_FLUSH;
    else if (load_use)    ctrl = CTRL_BUBBLE;
  end

  assign load_pc      = ctrl.load_pc;
  assign load_if_id   = ctrl.load_if_id;
  assign load_id_ex   = ctrl.load_id_ex;
  assign load_ex_mem  = ctrl.load_ex_mem;
  assign load_mem_wb  = ctrl.load_mem_wb;
  assign flush_if_id  = ctrl.flush_if_id;
  assign bubble_id_ex = ctrl.bubble_id_ex;
  assign stall_o      = mem_stall & ~rst;

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, bubble_cnt_q, flush_cnt_q;
  logic             bubble_evt, flush_evt;

  assign flush_evt  = ~mem_stall & ex_redirect;
  assign bubble_evt = ~mem_stall & ~ex_redirect & load_use;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
      flush_cnt_q  <= '0;
    end else begin
      if (mem_stall && stall_cnt_q != '1)   stall_cnt_q  <= stall_cnt_q + CNT_W'(1);
      if (bubble_evt && bubble_cnt_q != '1) bubble_cnt_q <= bubble_cnt_q + CNT_W'(1);
      if (flush_evt && flush_cnt_q != '1)   flush_cnt_q  <= flush_cnt_q + CNT_W'(1);
    end
  end

  assign stall_cycles_o = stall_cnt_q;
  assign bubble_cnt_o   = bubble_cnt_q;
  assign flush_cnt_o    = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: directed scenarios plus random traffic against a reference model.
module tb_pipeline_hazard_ctrl;

  localparam int RW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          imem_read, imem_resp, dmem_read, dmem_write, dmem_resp;
  logic [RW-1:0] id_rs1, id_rs2, ex_rd;
  logic          id_uses_rs1, id_uses_rs2, ex_is_load, ex_redirect;
  logic          load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb;
  logic          flush_if_id, bubble_id_ex, stall_o;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0]   stall_cycles_o, bubble_cnt_o, flush_cnt_o;
  int unsigned   m_stall_cnt, m_bubble_cnt, m_flush_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // per-port "response already received during this stall" (0 = imem, 1 = dmem)
  bit answered [2];

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.REG_ADDR_W(RW), .CNT_W(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .imem_read    (imem_read),
    .imem_resp    (imem_resp),
    .dmem_read    (dmem_read),
    .dmem_write   (dmem_write),
    .dmem_resp    (dmem_resp),
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .id_uses_rs1  (id_uses_rs1),
    .id_uses_rs2  (id_uses_rs2),
    .ex_is_load   (ex_is_load),
    .ex_rd        (ex_rd),
    .ex_redirect  (ex_redirect),
`ifdef HAZARD_PERF_CNT_EN
    .stall_cycles_o (stall_cycles_o),
    .bubble_cnt_o   (bubble_cnt_o),
    .flush_cnt_o    (flush_cnt_o),
`endif
    .load_pc      (load_pc),
    .load_if_id   (load_if_id),
    .load_id_ex   (load_id_ex),
    .load_ex_mem  (load_ex_mem),
    .load_mem_wb  (load_mem_wb),
    .flush_if_id  (flush_if_id),
    .bubble_id_ex (bubble_id_ex),
    .stall_o      (stall_o)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    imem_read = 0; imem_resp = 0; dmem_read = 0; dmem_write = 0; dmem_resp = 0;
    id_rs1 = 0; id_rs2 = 0; id_uses_rs1 = 0; id_uses_rs2 = 0;
    ex_is_load = 0; ex_rd = 0; ex_redirect = 0;
  endtask

  // Inputs are set shortly after a rising edge; this checks the combinational
  // outputs against the model, then advances the model and the clock.
  task automatic step(input string tag);
    bit          req [2];
    bit          rsp [2];
    bit          stalled, lu;
    logic [7:0]  exp, got;
    #2;
    req[0] = imem_read;  req[1] = dmem_read | dmem_write;
    rsp[0] = imem_resp;  rsp[1] = dmem_resp;
    stalled = 0;
    foreach (req[p]) if (req[p] && !answered[p] && !rsp[p]) stalled = 1;
    lu = ex_is_load && (ex_rd != 0) &&
         ((id_uses_rs1 && id_rs1 == ex_rd) || (id_uses_rs2 && id_rs2 == ex_rd));
    // {load_pc, if_id, id_ex, ex_mem, mem_wb, flush, bubble, stall}
    if (rst)              exp = 8'b00000_0_0_0;
    else if (stalled)     exp = 8'b00000_0_0_1;
    else if (ex_redirect) exp = 8'b11111_1_1_0;
    else if (lu)          exp = 8'b00111_0_1_0;
    else                  exp = 8'b11111_0_0_0;
    got = {load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb,
           flush_if_id, bubble_id_ex, stall_o};
    check(tag, 32'(got), 32'(exp));
`ifdef HAZARD_PERF_CNT_EN
    check({tag, "_stallcnt"},  stall_cycles_o, m_stall_cnt);
    check({tag, "_bubblecnt"}, bubble_cnt_o,   m_bubble_cnt);
    check({tag, "_flushcnt"},  flush_cnt_o,    m_flush_cnt);
    if (rst) begin
      m_stall_cnt = 0; m_bubble_cnt = 0; m_flush_cnt = 0;
    end else begin
      if (stalled && m_stall_cnt != 32'hFFFF_FFFF) m_stall_cnt++;
      if (!stalled && !ex_redirect && lu && m_bubble_cnt != 32'hFFFF_FFFF) m_bubble_cnt++;
      if (!stalled && ex_redirect && m_flush_cnt != 32'hFFFF_FFFF) m_flush_cnt++;
    end
`endif
    foreach (answered[p]) begin
      if (rst || !stalled) answered[p] = 0;
      else if (req[p] && rsp[p]) answered[p] = 1;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle_inputs();
    rst = 1;
    @(posedge clk); #1;
    step("reset0");
    step("reset1");
    rst = 0;
    step("idle");

    // fetch miss resolved in cycle 3
    imem_read = 1;
    step("tp1_c1");
    step("tp1_c2");
    imem_resp = 1; #1;
    check("tp1_c3_loadpc", 32'(load_pc), 32'd1);
    step("tp1_c3");
    idle_inputs();
    step("tp1_after");

    // imem answers early, dmem answers in cycle 5
    imem_read = 1; dmem_read = 1;
    step("tp2_c1");
    imem_resp = 1;
    step("tp2_c2");
    imem_resp = 0; #1;
    check("tp2_c3_stall", 32'(stall_o), 32'd1);
    step("tp2_c3");
    step("tp2_c4");
    dmem_resp = 1;
    step("tp2_c5");
    dmem_resp = 0; imem_read = 0; dmem_read = 0;
    step("tp2_c6");

    // load-use on rs2, then the same with x0
    ex_is_load = 1; ex_rd = 5; id_rs2 = 5; id_uses_rs2 = 1; #1;
    check("tp3_bubble", 32'(bubble_id_ex), 32'd1);
    step("tp3_lu");
    ex_rd = 0; id_rs2 = 0;
    step("tp3_x0");

    // redirect overrides load-use
    ex_rd = 7; id_rs1 = 7; id_uses_rs1 = 1; ex_redirect = 1; #1;
    check("tp4_flush", 32'(flush_if_id), 32'd1);
    step("tp4_redir_lu");
    idle_inputs();

    // redirect held during a store stall
    dmem_write = 1; ex_redirect = 1; #1;
    check("tp5_noflush", 32'(flush_if_id), 32'd0);
    step("tp5_c1");
    step("tp5_c2");
    dmem_resp = 1;
    step("tp5_adv");
    idle_inputs();

    // reset while waiting with an imem response captured
    imem_read = 1; dmem_read = 1;
    step("tp6_c1");
    imem_resp = 1;
    step("tp6_c2");
    imem_resp = 0; rst = 1;
    step("tp6_rst");
    rst = 0; dmem_read = 0;
    step("tp6_after_rst");
    imem_resp = 1;
    step("tp6_resp");
    idle_inputs();
    step("tp6_idle");

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      rst         = ($urandom_range(63) == 0);
      imem_read   = ($urandom_range(3) != 0);
      imem_resp   = ($urandom_range(2) == 0);
      dmem_read   = ($urandom_range(3) == 0);
      dmem_write  = ($urandom_range(5) == 0);
      dmem_resp   = ($urandom_range(2) == 0);
      id_rs1      = RW'($urandom_range(3));
      id_rs2      = RW'($urandom_range(3));
      ex_rd       = RW'($urandom_range(3));
      id_uses_rs1 = $urandom_range(1) == 1;
      id_uses_rs2 = $urandom_range(1) == 1;
      ex_is_load  = $urandom_range(1) == 1;
      ex_redirect = ($urandom_range(7) == 0);
      step("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
